div_unit: RTL and testbench



---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 21 ++
 rtl/div_unit.sv | 166 ++++++++++++++++
 tb/tb_div_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed/unsigned divider.
// The divider's optional unsigned mode is enabled by defining DIV_UNSIGNED_EN.
package div_pkg;

   localparam int DEF_WIDTH = 32;

   localparam logic [1:0] DIV_NONE  = 2'b00;
   localparam logic [1:0] DIV_START = 2'b01;
   localparam logic [1:0] DIV_ABORT = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// The divisor is never larger than 2^WIDTH-1, so the shifted remainder needs one extra bit.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             dividend_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;

   always_comb begin
      shifted = {rem_in, dividend_bit};
      q_bit   = (shifted >= {1'b0, divisor});
      rem_out = q_bit ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/div_unit.sv
// Iterative multicycle divider: hi = remainder, lo = quotient, one quotient bit per cycle.
// Define DIV_UNSIGNED_EN to add the isUnsigned input (DIVU behaviour).
module div_unit
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       divControl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef DIV_UNSIGNED_EN
   input  logic             isUnsigned,
`endif
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div0
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             sa_q, sa_d;
   logic             sq_q, sq_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             div0_q, div0_d;

   logic             unsigned_op;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] step_rem;
   logic             step_qbit;

`ifdef DIV_UNSIGNED_EN
   assign unsigned_op = isUnsigned;
`else
   assign unsigned_op = 1'b0;
`endif

   assign a_mag = (a[WIDTH-1] && !unsigned_op) ? -a : a;
   assign b_mag = (b[WIDTH-1] && !unsigned_op) ? -b : b;

   // The quotient register doubles as the dividend shift register.
   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .rem_in       (rem_q),
      .dividend_bit (quo_q[WIDTH-1]),
      .divisor      (dvs_q),
      .rem_out      (step_rem),
      .q_bit        (step_qbit)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      sa_d    = sa_q;
      sq_d    = sq_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      div0_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (divControl == DIV_START) begin
               if (b == '0) begin
                  // A zero-divisor start in the cycle done is already high is dropped
                  // so that done/div0 never stretch over two cycles.
                  if (!done_q) begin
                     done_d = 1'b1;
                     div0_d = 1'b1;
                  end
               end else begin
                  quo_d   = a_mag;
                  dvs_d   = b_mag;
                  sa_d    = a[WIDTH-1] && !unsigned_op;
                  sq_d    = (a[WIDTH-1] ^ b[WIDTH-1]) && !unsigned_op;
                  rem_d   = '0;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (divControl == DIV_ABORT) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               rem_d = step_rem;
               quo_d = {quo_q[WIDTH-2:0], step_qbit};
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d = ST_FIX;
               end
            end
         end
         ST_FIX: begin
            if (divControl == DIV_ABORT) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               lo_d    = sq_q ? -quo_q : quo_q;
               hi_d    = sa_q ? -rem_q : rem_q;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         sa_q    <= 1'b0;
         sq_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         div0_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         sa_q    <= sa_d;
         sq_q    <= sq_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         div0_q  <= div0_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = busy_q;
   assign done = done_q;
   assign div0 = div0_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands
// checked against a plain-arithmetic MIPS DIV/DIVU reference.
module tb_div_unit;

   logic        clk;
   logic        reset;
   logic [1:0]  divControl;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        is_uns;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        div0;

   int vectors     = 0;
   int miscompares = 0;

   div_unit #(
      .WIDTH(32),
      .CNT_W(6)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .divControl (divControl),
      .a          (a_in),
      .b          (b_in),
`ifdef DIV_UNSIGNED_EN
      .isUnsigned (is_uns),
`endif
      .hi         (hi),
      .lo         (lo),
      .busy       (busy),
      .done       (done),
      .div0       (div0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // MIPS semantics: truncate toward zero, remainder follows the dividend, results mod 2^32.
   function automatic void ref_div(input logic [31:0] av, input logic [31:0] bv, input bit uns,
                                   output logic [31:0] q, output logic [31:0] r);
      longint na, nb;
      if (uns) begin
         na = longint'({32'b0, av});
         nb = longint'({32'b0, bv});
      end else begin
         na = longint'($signed(av));
         nb = longint'($signed(bv));
      end
      q = 32'(na / nb);
      r = 32'(na % nb);
   endfunction

   // Drive a start for one edge; on return the start edge has passed (+1 time unit).
   task automatic issue_start(input logic [31:0] av, input logic [31:0] bv, input bit uns);
      @(negedge clk);
      a_in       = av;
      b_in       = bv;
      is_uns     = uns;
      divControl = 2'b01;
      @(posedge clk);
      #1;
      divControl = 2'b00;
   endtask

   task automatic op(input logic [31:0] av, input logic [31:0] bv, input bit uns);
      logic [31:0] eq, er, hi0, lo0;
      int n;
      hi0 = hi;
      lo0 = lo;
      issue_start(av, bv, uns);
      if (bv == 32'd0) begin
         check("z_done", {31'b0, done}, 32'd1);
         check("z_div0", {31'b0, div0}, 32'd1);
         check("z_busy", {31'b0, busy}, 32'd0);
         check("z_hi", hi, hi0);
         check("z_lo", lo, lo0);
         @(posedge clk);
         #1;
         check("z_done_drop", {31'b0, done}, 32'd0);
         check("z_div0_drop", {31'b0, div0}, 32'd0);
      end else begin
         ref_div(av, bv, uns, eq, er);
         check("busy_start", {31'b0, busy}, 32'd1);
         n = 0;
         while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
         end
         check("latency", n, 32'd33);
         check("lo", lo, eq);
         check("hi", hi, er);
         check("div0_low", {31'b0, div0}, 32'd0);
         check("busy_end", {31'b0, busy}, 32'd0);
         @(posedge clk);
         #1;
         check("done_drop", {31'b0, done}, 32'd0);
      end
      $display("op a=%h b=%h uns=%0d -> lo=%h hi=%h", av, bv, uns, lo, hi);
   endtask

   initial begin
      logic [31:0] hi0, lo0, rb;
      int n;
      bit saw_done;

      reset      = 1'b1;
      divControl = 2'b00;
      a_in       = '0;
      b_in       = '0;
      is_uns     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_div0", {31'b0, div0}, 32'd0);
      reset = 1'b0;

      op(32'd100, 32'd7, 1'b0);
      check("dir_100_7_lo", lo, 32'd14);
      check("dir_100_7_hi", hi, 32'd2);
      op(32'hFFFFFF9C, 32'd7, 1'b0);
      check("dir_m100_7_lo", lo, 32'hFFFFFFF2);
      check("dir_m100_7_hi", hi, 32'hFFFFFFFE);
      op(32'd100, 32'hFFFFFFF9, 1'b0);
      check("dir_100_m7_lo", lo, 32'hFFFFFFF2);
      check("dir_100_m7_hi", hi, 32'd2);
      op(32'd5, 32'd0, 1'b0);
      op(32'h80000000, 32'hFFFFFFFF, 1'b0);
      check("ovf_lo", lo, 32'h80000000);
      check("ovf_hi", hi, 32'd0);

      // Abort while idle is a no-op.
      hi0 = hi;
      lo0 = lo;
      @(negedge clk);
      divControl = 2'b10;
      @(posedge clk);
      #1;
      divControl = 2'b00;
      check("idle_abort_busy", {31'b0, busy}, 32'd0);
      check("idle_abort_done", {31'b0, done}, 32'd0);
      check("idle_abort_hi", hi, hi0);
      check("idle_abort_lo", lo, lo0);

      // Start while busy is ignored.
      issue_start(32'd100, 32'd7, 1'b0);
      repeat (9) @(posedge clk);
      #2;
      a_in       = 32'd9;
      b_in       = 32'd3;
      divControl = 2'b01;
      @(posedge clk);
      #1;
      divControl = 2'b00;
      n = 10;
      while (!done && n < 45) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("restart_latency", n, 32'd33);
      check("restart_lo", lo, 32'd14);
      check("restart_hi", hi, 32'd2);
      $display("restart-ignored op -> lo=%h hi=%h", lo, hi);

      // Abort mid-run.
      op(32'd1000, 32'd9, 1'b0);
      hi0 = hi;
      lo0 = lo;
      issue_start(32'd100, 32'd7, 1'b0);
      repeat (9) @(posedge clk);
      #2;
      divControl = 2'b10;
      @(posedge clk);
      #1;
      divControl = 2'b00;
      check("abort_busy", {31'b0, busy}, 32'd0);
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) saw_done = 1'b1;
      end
      check("abort_no_done", {31'b0, saw_done}, 32'd0);
      check("abort_hi", hi, hi0);
      check("abort_lo", lo, lo0);
      $display("abort op -> busy=%0d lo=%h hi=%h", busy, lo, hi);

      // Reset mid-run, then a fresh operation.
      issue_start(32'd100, 32'd7, 1'b0);
      repeat (14) @(posedge clk);
      #2;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("mid_rst_hi", hi, 32'd0);
      check("mid_rst_lo", lo, 32'd0);
      check("mid_rst_busy", {31'b0, busy}, 32'd0);
      check("mid_rst_done", {31'b0, done}, 32'd0);
      check("mid_rst_div0", {31'b0, div0}, 32'd0);
      $display("mid-op reset -> lo=%h hi=%h busy=%0d", lo, hi, busy);
      op(32'd9, 32'd3, 1'b0);
      check("post_rst_lo", lo, 32'd3);
      check("post_rst_hi", hi, 32'd0);

`ifdef DIV_UNSIGNED_EN
      op(32'hFFFFFFFF, 32'd2, 1'b1);
      check("divu_lo", lo, 32'h7FFFFFFF);
      check("divu_hi", hi, 32'd1);
      op(32'h80000000, 32'hFFFFFFFF, 1'b1);
      op(32'd7, 32'd0, 1'b1);
`endif

      for (int i = 0; i < 24; i++) begin
         rb = $urandom;
         if (i % 3 == 0) rb = 32'($urandom_range(1, 15));
         if (i % 5 == 1) rb = -rb;
         if (i % 11 == 7) rb = 32'd0;
`ifdef DIV_UNSIGNED_EN
         op($urandom, rb, 1'($urandom_range(0, 1)));
`else
         op($urandom, rb, 1'b0);
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
